hex_refresh_ctrl: RTL
=====================

HEX_REFRESH_CTRL -- requirements
Module: hex_refresh_ctrl

Interface
REQ-001 The block SHALL have parameter BLANK_PAT, default 7'h7F, the active-low segment pattern for a dark digit.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 wr_valid  input  1  digit write request.
REQ-005 wr_ready  output  1  write acceptance; a write is accepted on an edge where wr_valid=1 and wr_ready=1.
REQ-006 wr_addr  input  3  digit index; 0..5 valid.
REQ-007 wr_data  input  4  BCD digit value.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 dec_in  output  4  registered code driven to the shared external combinational BCD-to-7-segment decoder.
REQ-010 dec_out  input  7  active-low segments returned by the shared decoder for dec_in.
REQ-011 hex0..hex5  output  7 each  registered active-low segment drive for displays HEX0..HEX5.
REQ-012 busy  output  1  high while any digit is pending or a capture is in progress.
REQ-013 upd_done  output  1  one-cycle pulse when the last pending digit has been captured.

Function
REQ-014 The block SHALL hold six 4-bit digit registers and a 6-bit dirty vector; the decoder SHALL be shared by time-multiplexing, with one digit decoded per cycle.
REQ-015 wr_ready SHALL be 1 whenever rst_n=1.
REQ-016 An accepted write with wr_addr 0..5 SHALL update that digit register and set its dirty bit; a write with wr_addr 6 or 7 SHALL be accepted and discarded.
REQ-017 When blank_lz=1, an accepted valid write SHALL set all six dirty bits.
REQ-018 A change of blank_lz, detected against a registered copy, SHALL set all six dirty bits on the following edge.
REQ-019 The FSM SHALL have states IDLE and CAP.
REQ-020 In IDLE with dirty nonzero, the block SHALL select ptr = the lowest-index dirty digit, load dec_in with that digit, clear its dirty bit, and go to CAP.
REQ-021 In CAP, the block SHALL load hex[ptr] with the resolved pattern.
REQ-022 In CAP, if dirty is still nonzero, the block SHALL load the next lowest dirty digit in the same cycle and stay in CAP; otherwise it SHALL go to IDLE and pulse upd_done.
REQ-023 Resolved pattern = BLANK_PAT if digit > 9; otherwise BLANK_PAT if blank_lz=1, ptr != 0, and digit ptr and all higher digits are 0; otherwise dec_out.
REQ-024 Blanking SHALL use digit register values at the capture edge.
REQ-025 Latency: a write accepted at edge k with the FSM in IDLE and no other dirty bits SHALL update the hex output at edge k+2.
REQ-026 Throughput: with N digits pending, the block SHALL capture them on N consecutive edges.
REQ-027 If a dirty bit is set by a write on the same edge it is cleared by selection, set SHALL win, so the digit is decoded again.
REQ-028 A write to the digit currently in CAP SHALL NOT corrupt that capture; the new value SHALL be decoded in a later capture.
REQ-029 busy SHALL equal (state==CAP) OR (dirty != 0).
REQ-030 hex outputs SHALL change only on capture edges.

Reset
REQ-031 While rst_n=0 at a clock edge: digits=0, dirty=6'b111111, state=IDLE, dec_in=0, hex0..hex5=BLANK_PAT, upd_done=0, wr_ready=0, registered blank_lz copy=blank_lz.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep; no capture SHALL occur on the reset edge.
REQ-033 After reset release, the block SHALL perform an automatic full sweep.

Verification
REQ-034 Reset release, blank_lz=0, decoder model attached -> hex0..hex5 = 7'h40 ("0") after 7 cycles; upd_done pulses exactly once; busy then 0.
REQ-035 Idle, then write addr 3 data 7 at edge k -> hex3=7'h78 at edge k+2; other hex outputs unchanged; dirty empty.
REQ-036 Write data 4'hC to addr 1 -> hex1=7'h7F; write addr 6 data 5 -> no hex change and busy stays 0.
REQ-037 blank_lz=1 with digits 0,0,3,0,0,0 (hex0..hex5) -> full resweep; hex5, hex4, hex3 blank; hex2=7'h30; hex1 and hex0 show "0".
REQ-038 During a 6-digit sweep, write addr 0 with new value at the edge that captures digit 0 -> digit 0 re-decoded; final hex0 shows the new value.
REQ-039 rst_n=0 for one cycle mid-sweep -> all hex outputs = 7'h7F; a fresh full sweep follows.

Source files
------------

// File: rtl/hex_refresh_ctrl.sv
// Six-digit 7-segment refresh controller: digit writes mark entries dirty and a
// single shared BCD decoder is swept over the dirty digits, one digit per cycle.
module hex_refresh_ctrl #(
   parameter logic [6:0] BLANK_PAT = 7'h7F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       blank_lz,
   output logic [3:0] dec_in,
   input  logic [6:0] dec_out,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic [6:0] hex4,
   output logic [6:0] hex5,
   output logic       busy,
   output logic       upd_done
);

   typedef enum logic {IDLE, CAP} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_dig [6];
   logic [6:0]  r_hex [6];
   logic [5:0]  r_dirty, w_dirty_nxt, w_set, w_sel_oh;
   logic [2:0]  r_ptr, w_sel;
   logic [3:0]  r_dec_in, w_sel_dig;
   logic        r_blz, r_upd_done;
   logic        w_sel_vld, w_wr, w_load, w_cap, w_upd, w_hi_zero;
   logic [6:0]  w_pat;

   assign wr_ready = rst_n;
   assign w_wr     = wr_valid && wr_ready && (wr_addr < 3'd6);

   // Lowest-index dirty digit wins the decoder.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel     = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (r_dirty[i]) begin
            w_sel     = 3'(i);
            w_sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_dig = 4'd0;
      for (int i = 0; i < 6; i++)
         if (w_sel == 3'(i)) w_sel_dig = r_dig[i];
   end

   assign w_sel_oh = w_sel_vld ? (6'b000001 << w_sel) : 6'b000000;

   always_comb begin
      w_set = 6'b000000;
      if (w_wr) w_set = blank_lz ? 6'b111111 : (6'b000001 << wr_addr);
      if (blank_lz != r_blz) w_set = 6'b111111;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_cap       = 1'b0;
      w_upd       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sel_vld) begin
               w_load      = 1'b1;
               w_state_nxt = CAP;
            end
         end
         CAP: begin
            w_cap = 1'b1;
            if (w_sel_vld) begin
               w_load = 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_upd       = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A set on the same edge as the selection clear wins, forcing a re-decode.
   assign w_dirty_nxt = (r_dirty & ~(w_load ? w_sel_oh : 6'b000000)) | w_set;

   always_comb begin
      w_hi_zero = 1'b1;
      for (int j = 0; j < 6; j++)
         if ((3'(j) >= r_ptr) && (r_dig[j] != 4'd0)) w_hi_zero = 1'b0;
   end

   always_comb begin
      w_pat = dec_out;
      if (r_dec_in > 4'd9)
         w_pat = BLANK_PAT;
      else if (blank_lz && (r_ptr != 3'd0) && w_hi_zero)
         w_pat = BLANK_PAT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_dirty    <= 6'b111111;
         r_ptr      <= 3'd0;
         r_dec_in   <= 4'd0;
         r_blz      <= blank_lz;
         r_upd_done <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_dig[i] <= 4'd0;
            r_hex[i] <= BLANK_PAT;
         end
      end else begin
         r_state    <= w_state_nxt;
         r_dirty    <= w_dirty_nxt;
         r_blz      <= blank_lz;
         r_upd_done <= w_upd;
         if (w_load) begin
            r_ptr    <= w_sel;
            r_dec_in <= w_sel_dig;
         end
         for (int i = 0; i < 6; i++) begin
            if (w_wr && (wr_addr == 3'(i))) r_dig[i] <= wr_data;
            if (w_cap && (r_ptr == 3'(i)))  r_hex[i] <= w_pat;
         end
      end
   end

   assign dec_in   = r_dec_in;
   assign busy     = (r_state == CAP) || (r_dirty != 6'b000000);
   assign upd_done = r_upd_done;
   assign hex0     = r_hex[0];
   assign hex1     = r_hex[1];
   assign hex2     = r_hex[2];
   assign hex3     = r_hex[3];
   assign hex4     = r_hex[4];
   assign hex5     = r_hex[5];

endmodule
